poly_uniform_eta_stream: RTL

Parametrised ML-DSA/Dilithium `ExpandS` coefficient sampler. It produces one polynomial with coefficients in [-η, η], where η is 2 or 4 and selected per operation at run time. It drives an external SHAKE256 core through a message/start interface, consumes squeezed rate blocks over a valid/ready handshake, and performs rejection sampling one byte per cycle until N coefficients are accepted. It sits between the key-generation controller and the shared Keccak core, so one sampler serves all Dilithium security levels.

---
 rtl/poly_uniform_eta_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/poly_uniform_eta_stream.sv
// ExpandS coefficient sampler: drives a SHAKE256 core and rejection-samples
// nibbles into N coefficients in [-eta, eta], eta = 2 or 4 chosen per run.
module poly_uniform_eta_stream #(
  parameter int N          = 256,
  parameter int COEF_W     = 32,
  parameter int RATE_BYTES = 136
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    eta_sel,
  input  logic [511:0]            seed,
  input  logic [15:0]             nonce,
  output logic [527:0]            shk_msg,
  output logic                    shk_start,
  input  logic [8*RATE_BYTES-1:0] shk_block,
  input  logic                    shk_block_valid,
  output logic                    shk_block_ready,
  output logic [N*COEF_W-1:0]     a_out,
  output logic                    done,
  output logic                    busy
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = $clog2(RATE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_WAIT, S_SAMPLE, S_DONE
  } state_t;

  state_t                  state_q;
  logic                    eta_q;
  logic [527:0]            msg_q;
  logic                    go_q;
  logic                    rdy_q;
  logic [8*RATE_BYTES-1:0] buf_q;
  logic [BW-1:0]           bi_q;
  logic [CW-1:0]           ctr_q;
  logic [N*COEF_W-1:0]     a_q;
  logic                    done_q;
  logic                    busy_q;

  function automatic logic accept(input logic e4, input logic [3:0] t);
    return e4 ? (t < 4'd9) : (t < 4'd15);
  endfunction

  // t mod 5 via the reciprocal multiply used by the reference code
  function automatic logic [3:0] nib_val(input logic e4,
                                         input logic [3:0] t);
    logic [11:0] p;
    logic [3:0]  q;
    logic [3:0]  r;
    p = 12'(t) * 12'd205;
    q = {2'b00, p[11:10]};
    r = t - q * 4'd5;
    return e4 ? (4'd4 - t) : (4'd2 - r);
  endfunction

  logic [3:0]        t0, t1;
  logic              acc0, acc1;
  logic [CW-1:0]     idx1, ctr_d;
  logic [COEF_W-1:0] v0, v1;

  always_comb begin
    t0    = buf_q[3:0];
    t1    = buf_q[7:4];
    acc0  = accept(eta_q, t0);
    acc1  = accept(eta_q, t1) &&
            !(acc0 && (ctr_q == CW'(N - 1)));
    idx1  = acc0 ? ctr_q + CW'(1) : ctr_q;
    ctr_d = ctr_q + CW'(acc0) + CW'(acc1);
    v0    = COEF_W'(signed'(nib_val(eta_q, t0)));
    v1    = COEF_W'(signed'(nib_val(eta_q, t1)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      eta_q   <= 1'b0;
      msg_q   <= '0;
      go_q    <= 1'b0;
      rdy_q   <= 1'b0;
      buf_q   <= '0;
      bi_q    <= '0;
      ctr_q   <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            eta_q   <= eta_sel;
            msg_q   <= {nonce, seed};
            ctr_q   <= '0;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ABSORB;
          end
        end
        S_ABSORB: begin
          go_q    <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (shk_block_valid) begin
            buf_q   <= shk_block;
            bi_q    <= '0;
            rdy_q   <= 1'b0;
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          for (int i = 0; i < N; i++) begin
            if (acc0 && ctr_q == CW'(i))
              a_q[i*COEF_W +: COEF_W] <= v0;
            if (acc1 && idx1 == CW'(i))
              a_q[i*COEF_W +: COEF_W] <= v1;
          end
          ctr_q <= ctr_d;
          buf_q <= buf_q >> 8;
          if (ctr_d == CW'(N)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (bi_q == BW'(RATE_BYTES - 1)) begin
            rdy_q   <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            bi_q <= bi_q + BW'(1);
          end
        end
        S_DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shk_msg         = msg_q;
  assign shk_start       = go_q;
  assign shk_block_ready = rdy_q;
  assign a_out           = a_q;
  assign done            = done_q;
  assign busy            = busy_q;

endmodule
